fwd_operand_stage: RTL and testbench

- Parametrised successor to the EX-stage forwarding mux of the pipelined core.
- Holds the ID/EX operand register for NUM_OPND source operands.
- Resolves forwarding from NUM_SRC downstream stages by register-address compare and priority, and raises a load-use interlock.
- Re-latches forwarded values while EX is held, so a producer that retires during a stall is not lost.

---
 rtl/fwd_operand_stage_pkg.sv | 15 +
 rtl/fwd_operand_stage_prio.sv | 47 ++++
 rtl/fwd_operand_stage.sv | 120 ++++++++++++
 tb/tb_fwd_operand_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_operand_stage_pkg.sv
// Shared definitions for the EX-stage operand forwarding logic: default widths,
// the "use register value" select code and the select-width helper.
package fwd_operand_stage_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;

    // fwd_sel value meaning "no forwarding, use the stored register value"
    localparam int unsigned FWD_SEL_REG = 0;

    function automatic int unsigned fwd_sel_width(input int unsigned num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/fwd_operand_stage_prio.sv
// Match and priority mux for one source operand: the lowest-index (youngest)
// matching source wins; x0 never matches.
module fwd_prio_select
    import fwd_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned SEL_W      = fwd_sel_width(NUM_SRC)
) (
    input  logic                          en_i,
    input  logic [REG_ADDR_W-1:0]         rs_i,
    input  logic [DATA_W-1:0]             reg_data_i,
    input  logic [NUM_SRC-1:0]            src_wr_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd_i,
    input  logic [NUM_SRC-1:0]            src_ready_i,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data_i,
    output logic [DATA_W-1:0]             opnd_o,
    output logic [SEL_W-1:0]              sel_o,
    output logic                          fwd_o,
    output logic                          stall_o
);

    logic [NUM_SRC-1:0] match;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_match
        assign match[j] = en_i & src_wr_i[j] & (rs_i != '0) &
                          (src_rd_i[j*REG_ADDR_W +: REG_ADDR_W] == rs_i);
    end

    // Scan oldest to youngest so the youngest match is the last to assign.
    always_comb begin
        opnd_o  = reg_data_i;
        sel_o   = SEL_W'(FWD_SEL_REG);
        fwd_o   = 1'b0;
        stall_o = 1'b0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (match[j]) begin
                opnd_o  = src_data_i[j*DATA_W +: DATA_W];
                sel_o   = SEL_W'(j + 1);
                fwd_o   = src_ready_i[j];
                stall_o = ~src_ready_i[j];
            end
        end
    end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand register with multi-source forwarding, load-use interlock and
// stall-time capture of forwarded values, plus a saturating hazard counter.
module fwd_operand_stage
    import fwd_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_OPND   = 2,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SEL_W     = fwd_sel_width(NUM_SRC)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           id_valid_i,
    input  logic [NUM_OPND-1:0]            id_use_i,
    input  logic [NUM_OPND*REG_ADDR_W-1:0] id_rs_i,
    input  logic [NUM_OPND*DATA_W-1:0]     id_data_i,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic [NUM_SRC-1:0]             src_wr_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  src_rd_i,
    input  logic [NUM_SRC-1:0]             src_ready_i,
    input  logic [NUM_SRC*DATA_W-1:0]      src_data_i,
    output logic                           ex_valid_o,
    output logic [NUM_OPND*DATA_W-1:0]     ex_opnd_o,
    output logic [NUM_OPND*SEL_W-1:0]      fwd_sel_o,
    output logic                           hazard_o,
    output logic [CNT_W-1:0]               hazard_cnt_o
);

    logic                           ex_valid_q, ex_valid_d;
    logic [NUM_OPND-1:0]            use_q, use_d;
    logic [NUM_OPND*REG_ADDR_W-1:0] rs_q, rs_d;
    logic [NUM_OPND*DATA_W-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic [NUM_OPND*DATA_W-1:0]     fwd_data;
    logic [NUM_OPND*SEL_W-1:0]      fwd_sel;
    logic [NUM_OPND-1:0]            opnd_fwd;
    logic [NUM_OPND-1:0]            opnd_stall;
    logic                           hazard;
    logic                           hold;

    for (genvar k = 0; k < NUM_OPND; k++) begin : g_opnd
        fwd_prio_select #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_SRC    (NUM_SRC),
            .SEL_W      (SEL_W)
        ) u_prio (
            .en_i        (ex_valid_q & use_q[k]),
            .rs_i        (rs_q[k*REG_ADDR_W +: REG_ADDR_W]),
            .reg_data_i  (opnd_q[k*DATA_W +: DATA_W]),
            .src_wr_i    (src_wr_i),
            .src_rd_i    (src_rd_i),
            .src_ready_i (src_ready_i),
            .src_data_i  (src_data_i),
            .opnd_o      (fwd_data[k*DATA_W +: DATA_W]),
            .sel_o       (fwd_sel[k*SEL_W +: SEL_W]),
            .fwd_o       (opnd_fwd[k]),
            .stall_o     (opnd_stall[k])
        );
    end

    assign hazard = |opnd_stall;
    assign hold   = stall_i | hazard;

    always_comb begin
        ex_valid_d = ex_valid_q;
        use_d      = use_q;
        rs_d       = rs_q;
        opnd_d     = opnd_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (hold) begin
            // Capture ready forwarded data so it outlives the producer leaving the pipe.
            for (int k = 0; k < NUM_OPND; k++) begin
                if (opnd_fwd[k]) begin
                    opnd_d[k*DATA_W +: DATA_W] = fwd_data[k*DATA_W +: DATA_W];
                end
            end
        end else begin
            ex_valid_d = id_valid_i;
            use_d      = id_use_i;
            rs_d       = id_rs_i;
            opnd_d     = id_data_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q <= 1'b0;
            use_q      <= '0;
            rs_q       <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            use_q      <= use_d;
            rs_q       <= rs_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_opnd_o    = fwd_data;
    assign fwd_sel_o    = fwd_sel;
    assign hazard_o     = hazard;
    assign hazard_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed and randomized checks of fwd_operand_stage against a behavioural
// model; a second instance with a 2-bit counter covers saturation.
module tb_fwd_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NS = 2;
    localparam int unsigned NO = 2;
    localparam int unsigned SW = 2;

    logic              clk = 1'b0;
    logic              rst, id_valid, stall, flush;
    logic [NO-1:0]     id_use;
    logic [NO*AW-1:0]  id_rs;
    logic [NO*DW-1:0]  id_data;
    logic [NS-1:0]     src_wr, src_ready;
    logic [NS*AW-1:0]  src_rd;
    logic [NS*DW-1:0]  src_data;

    logic              ex_valid, hazard, ex_valid_b, hazard_b;
    logic [NO*DW-1:0]  ex_opnd, ex_opnd_b;
    logic [NO*SW-1:0]  fwd_sel, fwd_sel_b;
    logic [15:0]       cnt16;
    logic [1:0]        cnt2;

    fwd_operand_stage #(
        .DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .NUM_OPND(NO), .CNT_W(16)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_use_i(id_use),
        .id_rs_i(id_rs), .id_data_i(id_data), .stall_i(stall), .flush_i(flush),
        .src_wr_i(src_wr), .src_rd_i(src_rd), .src_ready_i(src_ready),
        .src_data_i(src_data), .ex_valid_o(ex_valid), .ex_opnd_o(ex_opnd),
        .fwd_sel_o(fwd_sel), .hazard_o(hazard), .hazard_cnt_o(cnt16)
    );

    fwd_operand_stage #(
        .DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .NUM_OPND(NO), .CNT_W(2)
    ) u_dut_sat (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_use_i(id_use),
        .id_rs_i(id_rs), .id_data_i(id_data), .stall_i(stall), .flush_i(flush),
        .src_wr_i(src_wr), .src_rd_i(src_rd), .src_ready_i(src_ready),
        .src_data_i(src_data), .ex_valid_o(ex_valid_b), .ex_opnd_o(ex_opnd_b),
        .fwd_sel_o(fwd_sel_b), .hazard_o(hazard_b), .hazard_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    // Behavioural model of the EX register contents.
    logic          m_valid;
    logic [NO-1:0] m_use;
    logic [AW-1:0] m_rs [NO];
    logic [DW-1:0] m_op [NO];
    int            m_cnt16, m_cnt2;
    int            n_cmp, n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First matching source in age order (youngest first) supplies the operand.
    function automatic void resolve(input int k, output logic [DW-1:0] val,
                                    output int sel, output bit haz);
        val = m_op[k];
        sel = 0;
        haz = 1'b0;
        if (m_valid && m_use[k] && m_rs[k] != '0) begin
            for (int j = 0; j < int'(NS); j++) begin
                if (sel == 0 && src_wr[j] && src_rd[j*AW +: AW] == m_rs[k]) begin
                    sel = j + 1;
                    val = src_data[j*DW +: DW];
                    haz = !src_ready[j];
                end
            end
        end
    endfunction

    task automatic check_model();
        logic [DW-1:0]    v;
        int               s;
        bit               h;
        bit               any_h = 1'b0;
        logic [NO*SW-1:0] exp_sel;
        logic [NO*DW-1:0] exp_op;
        for (int k = 0; k < int'(NO); k++) begin
            resolve(k, v, s, h);
            any_h = any_h | h;
            exp_sel[k*SW +: SW] = s[SW-1:0];
            exp_op[k*DW +: DW]  = v;
        end
        chk("ex_valid", 64'(ex_valid), 64'(m_valid));
        chk("fwd_sel", 64'(fwd_sel), 64'(exp_sel));
        chk("hazard", 64'(hazard), 64'(any_h));
        chk("hazard_cnt16", 64'(cnt16), 64'(m_cnt16));
        chk("hazard_cnt2", 64'(cnt2), 64'(m_cnt2));
        chk("sat_ex_valid", 64'(ex_valid_b), 64'(m_valid));
        chk("sat_fwd_sel", 64'(fwd_sel_b), 64'(exp_sel));
        chk("sat_hazard", 64'(hazard_b), 64'(any_h));
        if (!any_h) begin
            chk("ex_opnd", ex_opnd, exp_op);
            chk("sat_ex_opnd", ex_opnd_b, exp_op);
        end
    endtask

    task automatic commit();
        logic [DW-1:0] v [NO];
        int            s [NO];
        bit            h [NO];
        bit            any_h = 1'b0;
        for (int k = 0; k < int'(NO); k++) begin
            resolve(k, v[k], s[k], h[k]);
            any_h = any_h | h[k];
        end
        if (rst) begin
            m_valid = 1'b0;
            m_use   = '0;
            m_cnt16 = 0;
            m_cnt2  = 0;
            for (int k = 0; k < int'(NO); k++) begin
                m_rs[k] = '0;
                m_op[k] = '0;
            end
        end else begin
            if (any_h) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (flush) begin
                m_valid = 1'b0;
            end else if (stall || any_h) begin
                for (int k = 0; k < int'(NO); k++)
                    if (s[k] != 0 && !h[k]) m_op[k] = v[k];
            end else begin
                m_valid = id_valid;
                m_use   = id_use;
                for (int k = 0; k < int'(NO); k++) begin
                    m_rs[k] = id_rs[k*AW +: AW];
                    m_op[k] = id_data[k*DW +: DW];
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic step();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [NO-1:0] u, input logic [AW-1:0] r0,
                          input logic [AW-1:0] r1, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1);
        id_valid = v;
        id_use   = u;
        id_rs    = {r1, r0};
        id_data  = {d1, d0};
    endtask

    task automatic set_src(input int j, input logic wr, input logic [AW-1:0] rd,
                           input logic rdy, input logic [DW-1:0] d);
        src_wr[j]             = wr;
        src_rd[j*AW +: AW]    = rd;
        src_ready[j]          = rdy;
        src_data[j*DW +: DW]  = d;
    endtask

    task automatic clr_src();
        src_wr    = '0;
        src_rd    = '0;
        src_ready = '1;
        src_data  = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        clr_src();
        step();
        step();
        settle();
        chk("rst_ex_valid", 64'(ex_valid), 64'h0);
        chk("rst_ex_opnd", ex_opnd, 64'h0);
        rst = 1'b0;

        // Priority: MEM beats WB, then WB alone.
        set_id(1'b1, 2'b11, 5'd5, 5'd6, 32'h11111111, 32'h22222222);
        step();
        stall = 1'b1;
        set_id(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        set_src(0, 1'b1, 5'd5, 1'b1, 32'hAAAA0000);
        set_src(1, 1'b1, 5'd5, 1'b1, 32'h0000BBBB);
        settle();
        chk("prio_mem_val", 64'(ex_opnd[31:0]), 64'hAAAA0000);
        chk("prio_mem_sel", 64'(fwd_sel[1:0]), 64'h1);
        step();
        set_src(0, 1'b0, 5'd0, 1'b1, 32'h0);
        settle();
        chk("prio_wb_val", 64'(ex_opnd[31:0]), 64'h0000BBBB);
        chk("prio_wb_sel", 64'(fwd_sel[1:0]), 64'h2);
        step();
        stall = 1'b0;
        clr_src();

        // x0 is never forwarded; an unused operand neither forwards nor stalls.
        set_id(1'b1, 2'b01, 5'd0, 5'd7, 32'h0, 32'h77);
        step();
        set_id(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        set_src(0, 1'b1, 5'd7, 1'b0, 32'h7777);
        set_src(1, 1'b1, 5'd0, 1'b1, 32'hDEADBEEF);
        settle();
        chk("x0_val", 64'(ex_opnd[31:0]), 64'h0);
        chk("x0_sel", 64'(fwd_sel[1:0]), 64'h0);
        chk("unused_sel", 64'(fwd_sel[3:2]), 64'h0);
        chk("unused_hazard", 64'(hazard), 64'h0);
        step();
        clr_src();

        // Load-use: one hazard cycle, then the load arrives from WB.
        set_id(1'b1, 2'b11, 5'd1, 5'd9, 32'h1, 32'h9);
        step();
        set_id(1'b1, 2'b11, 5'd2, 5'd2, 32'hA, 32'hB);
        set_src(0, 1'b1, 5'd9, 1'b0, 32'hFFFF);
        settle();
        chk("lu_hazard", 64'(hazard), 64'h1);
        step();
        clr_src();
        set_src(1, 1'b1, 5'd9, 1'b1, 32'h12345678);
        settle();
        chk("lu_hazard_clear", 64'(hazard), 64'h0);
        chk("lu_val", 64'(ex_opnd[63:32]), 64'h12345678);
        chk("lu_cnt", 64'(cnt16), 64'h1);
        step();
        clr_src();

        // Stall capture: WB forwards x3 only in the first stall cycle.
        set_id(1'b1, 2'b01, 5'd3, 5'd0, 32'h0, 32'h0);
        step();
        set_id(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        stall = 1'b1;
        set_src(1, 1'b1, 5'd3, 1'b1, 32'h55);
        settle();
        step();
        clr_src();
        settle();
        step();
        settle();
        step();
        stall = 1'b0;
        settle();
        chk("cap_val", 64'(ex_opnd[31:0]), 64'h55);
        chk("cap_sel", 64'(fwd_sel[1:0]), 64'h0);
        step();

        // Flush wins over stall.
        set_id(1'b1, 2'b11, 5'd4, 5'd5, 32'h1, 32'h2);
        step();
        settle();
        chk("fl_pre_valid", 64'(ex_valid), 64'h1);
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        settle();
        chk("fl_valid", 64'(ex_valid), 64'h0);

        // Saturation: five hazard cycles on the 2-bit counter.
        set_id(1'b1, 2'b01, 5'd4, 5'd0, 32'h0, 32'h0);
        step();
        set_id(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        set_src(0, 1'b1, 5'd4, 1'b0, 32'h1);
        repeat (5) begin
            settle();
            step();
        end
        settle();
        chk("sat_cnt", 64'(cnt2), 64'h3);

        // Reset with a hazard pending.
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("rst_mid_valid", 64'(ex_valid), 64'h0);
        chk("rst_mid_hazard", 64'(hazard), 64'h0);
        chk("rst_mid_cnt", 64'(cnt16), 64'h0);
        chk("rst_mid_opnd", ex_opnd, 64'h0);
        step();
        clr_src();

        // Randomized traffic with small address range to provoke matches.
        repeat (400) begin
            rst      = ($urandom_range(63) == 0);
            stall    = ($urandom_range(3) == 0);
            flush    = ($urandom_range(7) == 0);
            id_valid = 1'($urandom_range(1));
            id_use   = NO'($urandom_range(3));
            for (int k = 0; k < int'(NO); k++) begin
                id_rs[k*AW +: AW]   = AW'($urandom_range(7));
                id_data[k*DW +: DW] = $urandom;
            end
            for (int j = 0; j < int'(NS); j++)
                set_src(j, 1'($urandom_range(1)), AW'($urandom_range(7)),
                        ($urandom_range(3) != 0), $urandom);
            settle();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
